hall_angle_estimator: RTL and testbench



---
 rtl/spwm_pkg.sv | 36 +++
 rtl/hall_debounce.sv | 53 +++++
 rtl/hall_angle_estimator.sv | 140 ++++++++++++++
 tb/tb_hall_angle_estimator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared SPWM definitions: angle/sector constants, sector base-angle table,
// hall-to-sector decode and the hall estimator state encoding.
package spwm_pkg;

    localparam int ANGLE_W      = 10;
    localparam int SECTOR_W_CNT = 171;

    localparam logic [2:0] SECTOR_UNKNOWN = 3'd7;

    // Base angle of each sector; entries 6 and 7 are unused padding so any
    // 3-bit sector value indexes the table safely.
    localparam logic [7:0][ANGLE_W-1:0] BASE_ANGLE = {
        10'd0, 10'd0, 10'd853, 10'd683, 10'd512, 10'd341, 10'd171, 10'd0
    };

    typedef enum logic [1:0] {INIT, SYNC, TRACK, FAULT} est_state_t;

    // Forward order 011,001,101,100,110,010 maps to sectors 0..5.
    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        case (code)
            3'b011:  return 3'd0;
            3'b001:  return 3'd1;
            3'b101:  return 3'd2;
            3'b100:  return 3'd3;
            3'b110:  return 3'd4;
            3'b010:  return 3'd5;
            default: return SECTOR_UNKNOWN;
        endcase
    endfunction

    // Next sector in the forward direction, modulo 6.
    function automatic logic [2:0] sector_inc(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop hall synchroniser followed by a stability counter: a new code is
// accepted once it has been stable for DEB_CYCLES consecutive clocks.
module hall_debounce
    import spwm_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       accept
);

    localparam logic [7:0] DEB_LIMIT = 8'(DEB_CYCLES);

    logic [2:0] sync1, sync2, last;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // Count of consecutive clocks the candidate has been stable, including this one.
    always_comb begin
        cnt_next = (sync2 != last) ? 8'd1 : cnt + 8'd1;
    end

    // Synchronise, track stability and accept a changed code once it has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            last   <= '0;
            cnt    <= '0;
            code   <= '0;
            accept <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchroniser chain.
            sync1  <= hall;
            sync2  <= sync1;
            last   <= sync2;
            accept <= 1'b0;
            if (sync2 == code) begin
                cnt <= '0;
            end else if (cnt_next == DEB_LIMIT) begin
                code   <= sync2;
                accept <= 1'b1;
                cnt    <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/hall_angle_estimator.sv
// Hall-sensor angle estimator: debounced hall codes drive a sector/direction
// tracker, and a division-free accumulator interpolates the 10-bit angle
// between hall edges. Optional macro ANGLE_OFFSET_EN adds a registered
// angle_offset input that is summed into angle_out.
module hall_angle_estimator
    import spwm_pkg::*;
#(
    parameter int                  DEB_CYCLES  = 16,
    parameter int                  PERIOD_W    = 20,
    parameter logic [PERIOD_W-1:0] STALL_COUNT = 20'hFFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          hall,
`ifdef ANGLE_OFFSET_EN
    input  logic [ANGLE_W-1:0]  angle_offset,
`endif
    output logic [ANGLE_W-1:0]  angle_out,
    output logic                angle_valid,
    output logic [2:0]          sector,
    output logic                dir,
    output logic                hall_fault,
    output logic [PERIOD_W-1:0] period
);

    localparam logic [PERIOD_W:0]   W_STEP   = (PERIOD_W+1)'(SECTOR_W_CNT);
    localparam logic [PERIOD_W-1:0] STALL_M1 = STALL_COUNT - 1'b1;

    est_state_t          state, state_next;
    logic [2:0]          code;
    logic                accept;
    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W:0]   acc, acc_sum;
    logic [ANGLE_W-1:0]  angle_int, limit, lo, hi;
    logic [2:0]          new_sec;
    logic                legal, is_fwd, is_rev, adjacent, stall_hit;

    hall_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .hall   (hall),
        .code   (code),
        .accept (accept)
    );

    // Classify the accepted code and choose the next tracker state.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        new_sec    = hall_to_sector(code);
        legal      = (new_sec != SECTOR_UNKNOWN);
        is_fwd     = legal && (sector != SECTOR_UNKNOWN) && (new_sec == sector_inc(sector));
        is_rev     = legal && (sector != SECTOR_UNKNOWN) && (sector_inc(new_sec) == sector);
        adjacent   = is_fwd || is_rev;
        stall_hit  = (count == STALL_M1);
        lo         = BASE_ANGLE[new_sec];
        hi         = BASE_ANGLE[sector_inc(new_sec)] - 10'd1;
        acc_sum    = acc + W_STEP;
        state_next = state;
        if (accept) begin
            if (!legal) begin
                state_next = FAULT;
            end else begin
                case (state)
                    INIT:        state_next = SYNC;
                    SYNC, TRACK: state_next = adjacent ? TRACK : FAULT;
                    FAULT:       state_next = adjacent ? SYNC : FAULT;
                    default:     state_next = INIT;
                endcase
            end
        end else if (stall_hit && state == TRACK) begin
            // Other states already report angle_valid low and wait for a hall edge.
            state_next = SYNC;
        end
    end

    // Tracker state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // Sector, direction, period measurement and angle interpolation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sector     <= SECTOR_UNKNOWN;
            dir        <= 1'b1;
            hall_fault <= 1'b0;
            period     <= '0;
            count      <= '0;
            acc        <= '0;
            angle_int  <= '0;
            limit      <= '0;
        end else if (accept) begin
            // A hall acceptance takes priority over a coincident stall.
            if (!legal) begin
                sector     <= SECTOR_UNKNOWN;
                hall_fault <= 1'b1;
            end else begin
                sector <= new_sec;
                count  <= PERIOD_W'(1);
                acc    <= '0;
                if (adjacent) begin
                    dir       <= is_fwd;
                    angle_int <= is_fwd ? lo : hi;
                    limit     <= is_fwd ? hi : lo;
                    if (state == FAULT) hall_fault <= 1'b0;
                    else                period     <= count;
                end else begin
                    // Non-adjacent code becomes the resync point.
                    angle_int <= lo;
                    limit     <= lo;
                    if (state != INIT) hall_fault <= 1'b1;
                end
            end
        end else begin
            if (count != STALL_COUNT) count <= count + 1'b1;
            if (state == TRACK && angle_int != limit) begin
                if (acc_sum >= {1'b0, period}) begin
                    acc       <= acc_sum - {1'b0, period};
                    angle_int <= dir ? angle_int + 10'd1 : angle_int - 10'd1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign angle_valid = (state == TRACK);

`ifdef ANGLE_OFFSET_EN
    // Apply the phase offset in a register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) angle_out <= '0;
        else     angle_out <= angle_int + angle_offset;
    end
`else
    assign angle_out = angle_int;
`endif

endmodule

// File: tb/tb_hall_angle_estimator.sv
// Directed bench for hall_angle_estimator: forward/reverse tracking,
// saturation at sector edges, glitch rejection, illegal-code fault recovery,
// stall detection and asynchronous reset. STALL_COUNT is shortened so the
// stall scenario stays brief.
module tb_hall_angle_estimator;

    localparam int PERIOD_W = 20;
    localparam int STALL    = 6000;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          hall;
    logic [9:0]          angle_out;
    logic                angle_valid;
    logic [2:0]          sector;
    logic                dir;
    logic                hall_fault;
    logic [PERIOD_W-1:0] period;

    int n_tests = 0;
    int n_fail  = 0;

    hall_angle_estimator #(
        .DEB_CYCLES  (16),
        .PERIOD_W    (PERIOD_W),
        .STALL_COUNT (20'(STALL))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hall        (hall),
`ifdef ANGLE_OFFSET_EN
        .angle_offset(10'd0),
`endif
        .angle_out   (angle_out),
        .angle_valid (angle_valid),
        .sector      (sector),
        .dir         (dir),
        .hall_fault  (hall_fault),
        .period      (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        hall = 3'b011;
        tick(3);
        check("rst_angle",  32'(angle_out),   32'd0);
        check("rst_valid",  32'(angle_valid), 32'd0);
        check("rst_sector", 32'(sector),      32'd7);
        check("rst_dir",    32'(dir),         32'd1);
        check("rst_fault",  32'(hall_fault),  32'd0);
        check("rst_period", 32'(period),      32'd0);
        rst = 1'b0;

        // Sector 0 acquired: SYNC, not yet valid.
        tick(1700);
        check("sync_sector", 32'(sector),      32'd0);
        check("sync_valid",  32'(angle_valid), 32'd0);
        check("sync_angle",  32'(angle_out),   32'd0);

        hall = 3'b001;
        tick(1710);
        check("trk_valid",  32'(angle_valid), 32'd1);
        check("trk_sector", 32'(sector),      32'd1);
        check("trk_dir",    32'(dir),         32'd1);

        // Forward into sector 2: 19-clock latency, then +1 every 10 clocks.
        hall = 3'b101;
        tick(18);
        check("fwd_s1_sat",    32'(angle_out), 32'd340);
        check("fwd_s1_hold",   32'(sector),    32'd1);
        tick(1);
        check("fwd_s2_base",   32'(angle_out), 32'd341);
        check("fwd_s2_sector", 32'(sector),    32'd2);
        check("fwd_s2_period", 32'(period),    32'd1710);
        check("fwd_s2_dir",    32'(dir),       32'd1);
        tick(81);
        check("fwd_s2_ang81",  32'(angle_out), 32'd349);
        tick(10);
        check("fwd_s2_ang91",  32'(angle_out), 32'd350);
        tick(1600);

        hall = 3'b100;
        tick(10);
        check("fwd_s2_sat",    32'(angle_out), 32'd511);
        check("fwd_s2_hold",   32'(sector),    32'd2);
        tick(90);
        check("fwd_s3_sector", 32'(sector),    32'd3);
        check("fwd_s3_angle",  32'(angle_out), 32'd520);
        tick(400);
        // Short glitch must not be accepted.
        hall = 3'b110;
        tick(10);
        hall = 3'b100;
        tick(50);
        check("glitch_sector", 32'(sector),    32'd3);
        tick(1150);

        hall = 3'b110;
        tick(100);
        check("glitch_period", 32'(period),    32'd1710);
        check("fwd_s4_sector", 32'(sector),    32'd4);
        tick(1610);

        // Reverse run 100, 101, 001.
        hall = 3'b100;
        tick(100);
        check("rev_s3_sector", 32'(sector),    32'd3);
        check("rev_s3_dir",    32'(dir),       32'd0);
        check("rev_s3_angle",  32'(angle_out), 32'd674);
        check("rev_s3_period", 32'(period),    32'd1710);
        tick(1610);
        hall = 3'b101;
        tick(1710);
        hall = 3'b001;
        tick(18);
        check("rev_s2_sat",    32'(angle_out), 32'd341);
        tick(1);
        check("rev_s1_entry",  32'(angle_out), 32'd340);
        check("rev_s1_sector", 32'(sector),    32'd1);
        check("rev_s1_dir",    32'(dir),       32'd0);
        tick(81);
        check("rev_s1_ang81",  32'(angle_out), 32'd332);
        tick(1610);

        // Illegal code 111.
        hall = 3'b111;
        tick(10);
        check("rev_s1_sat",    32'(angle_out),   32'd171);
        tick(10);
        check("ill_fault",     32'(hall_fault),  32'd1);
        check("ill_valid",     32'(angle_valid), 32'd0);
        check("ill_sector",    32'(sector),      32'd7);
        hall = 3'b001;
        tick(200);
        check("resync_fault",  32'(hall_fault),  32'd1);
        check("resync_sector", 32'(sector),      32'd1);
        hall = 3'b101;
        tick(200);
        check("rec_fault",     32'(hall_fault),  32'd0);
        check("rec_valid",     32'(angle_valid), 32'd0);
        check("rec_sector",    32'(sector),      32'd2);
        hall = 3'b100;
        tick(100);
        check("rec_track",     32'(angle_valid), 32'd1);
        check("rec_period",    32'(period),      32'd200);

        // Stall: hold 100 until the period counter saturates.
        tick(2900);
        check("pre_stall_valid", 32'(angle_valid), 32'd1);
        check("pre_stall_angle", 32'(angle_out),   32'd682);
        tick(3100);
        check("stall_valid",     32'(angle_valid), 32'd0);
        check("stall_angle",     32'(angle_out),   32'd682);
        hall = 3'b110;
        tick(30);
        check("stall_period",    32'(period),      32'(STALL));
        check("stall_retrack",   32'(angle_valid), 32'd1);
        check("stall_sector",    32'(sector),      32'd4);

        // Asynchronous reset mid-TRACK, away from a clock edge.
        tick(45);
        #3;
        rst = 1'b1;
        #1;
        check("arst_angle",  32'(angle_out),   32'd0);
        check("arst_sector", 32'(sector),      32'd7);
        check("arst_valid",  32'(angle_valid), 32'd0);
        check("arst_fault",  32'(hall_fault),  32'd0);
        check("arst_period", 32'(period),      32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
